spi_lcd_feeder: RTL and testbench

Upstream feeder for the 8-bit SPI master core. It buffers tagged entries (command byte, data byte, delay, end-of-transfer) from game/display logic in a FIFO. It drains them into the SPI core through the core's data/chip-select/ready handshake. It drives the panel D/C line and inserts programmable delays and CS-high gaps between transfers.

---
 rtl/spi_lcd_pkg.sv | 9 +
 rtl/sync_fifo.sv | 47 ++++
 rtl/spi_lcd_feeder.sv | 101 ++++++++++
 tb/tb_spi_lcd_feeder.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/spi_lcd_pkg.sv
// spi_lcd_pkg: shared entry tags, FSM states and FIFO entry width for the LCD SPI feeder
package spi_lcd_pkg;
  localparam int ENTRY_W = 10;
  localparam logic [1:0] TAG_CMD   = 2'b00;
  localparam logic [1:0] TAG_DATA  = 2'b01;
  localparam logic [1:0] TAG_DELAY = 2'b10;
  localparam logic [1:0] TAG_END   = 2'b11;
  typedef enum logic [1:0] {IDLE, XFER, GAP, DELAY} state_t;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: show-ahead synchronous FIFO; a write while full is still taken when a pop frees a slot
module sync_fifo
  import spi_lcd_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int W = ENTRY_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [W-1:0]             wr_data,
  input  logic                     rd_en,
  output logic [W-1:0]             rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0] level_q, level_d;
  logic push, pop;
  always_comb begin
    pop = rd_en && level_q != '0;
    push = wr_en && (level_q != FULL_LVL || pop);
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    level_d = level_q + (AW+1)'(push) - (AW+1)'(pop);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q <= level_d;
    end
  end
  always_ff @(posedge clk) if (push) mem[wr_ptr_q] <= wr_data;
  assign rd_data = mem[rd_ptr_q];
  assign full = level_q == FULL_LVL;
  assign empty = level_q == '0;
  assign level = level_q;
endmodule

// File: rtl/spi_lcd_feeder.sv
// spi_lcd_feeder: drains tagged FIFO entries into the 8-bit SPI core with D/C, delays and CS gaps
module spi_lcd_feeder
  import spi_lcd_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int CS_GAP_CYCLES = 4,
  parameter int DELAY_TICKS = 40000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wr_en,
  input  logic [1:0]                    wr_tag,
  input  logic [7:0]                    wr_byte,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          busy,
  output logic                          overflow,
  output logic [7:0]                    spi_data,
  output logic                          spi_cs_n,
  input  logic                          spi_rdy,
  output logic                          dc
);
  localparam logic [23:0] GAP_LOAD = 24'(CS_GAP_CYCLES - 1);
  state_t state_q, state_d;
  logic [23:0] cnt_q, cnt_d;
  logic [7:0] data_q, data_d;
  logic cs_n_q, cs_n_d, dc_q, dc_d, ovf_q, ovf_d, pop, launch;
  logic [ENTRY_W-1:0] head;
  logic [1:0] head_tag;
  logic [7:0] head_byte;
  sync_fifo #(.DEPTH(FIFO_DEPTH), .W(ENTRY_W)) u_fifo (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data({wr_tag, wr_byte}), .rd_en(pop),
    .rd_data(head), .full(full), .empty(empty), .level(level)
  );
  assign head_tag = head[9:8];
  assign head_byte = head[7:0];
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    cs_n_d = cs_n_q;
    data_d = data_q;
    dc_d = dc_q;
    pop = 1'b0;
    // the last gap cycle doubles as IDLE so the next transfer starts on that same edge
    launch = state_q == IDLE || (state_q == GAP && cnt_q == '0);
    if (launch) begin
      state_d = IDLE;
      pop = !empty;
      if (!empty && head_tag == TAG_DELAY) begin
        cnt_d = 24'(head_byte) * 24'(DELAY_TICKS);
        state_d = DELAY;
      end else if (!empty && !head_tag[1]) begin
        data_d = head_byte;
        dc_d = head_tag[0];
        cs_n_d = 1'b0;
        state_d = XFER;
      end
    end else if (state_q == GAP) begin
      cnt_d = cnt_q - 24'd1;
    end else if (state_q == DELAY) begin
      state_d = cnt_q == '0 ? IDLE : DELAY;
      cnt_d = cnt_q == '0 ? cnt_q : cnt_q - 24'd1;
    end else if (spi_rdy) begin
      if (!empty && !head_tag[1]) begin
        pop = 1'b1;
        data_d = head_byte;
        dc_d = head_tag[0];
      end else begin
        // a queued DELAY stays at the head and is consumed from IDLE after the gap
        pop = !empty && head_tag == TAG_END;
        cs_n_d = 1'b1;
        cnt_d = GAP_LOAD;
        state_d = GAP;
      end
    end
    ovf_d = ovf_q | (wr_en & full & ~pop);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      cs_n_q <= 1'b1;
      data_q <= '0;
      dc_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      cs_n_q <= cs_n_d;
      data_q <= data_d;
      dc_q <= dc_d;
      ovf_q <= ovf_d;
    end
  end
  assign spi_cs_n = cs_n_q;
  assign spi_data = data_q;
  assign dc = dc_q;
  assign overflow = ovf_q;
  assign busy = state_q != IDLE || !empty;
endmodule

// File: tb/tb_spi_lcd_feeder.sv
// tb_spi_lcd_feeder: directed bench with an SPI core model, byte scoreboard and CS-gap monitor
module tb_spi_lcd_feeder;
  localparam int DEPTH = 16;
  localparam int GAP = 4;
  localparam int TICKS = 4;
  localparam logic [1:0] CMD = 2'b00, DAT = 2'b01, DLY = 2'b10, ENDT = 2'b11;
  logic clk = 1'b0, rst = 1'b1, wr_en = 1'b0, spi_rdy = 1'b0;
  logic [1:0] wr_tag = '0;
  logic [7:0] wr_byte = '0;
  logic full, empty, busy, overflow, spi_cs_n, dc;
  logic [4:0] level;
  logic [7:0] spi_data;
  int checks = 0, fails = 0, n_latch = 0, n_fall = 0, hi = 0, last_hi = 0, tmr = 0;
  int f0, l0;
  bit core_en = 1'b1, armed = 1'b0, m_ovf = 1'b0;
  logic prev_cs = 1'b1;
  logic [8:0] exp_q[$];

  always #5 clk = ~clk;

  spi_lcd_feeder #(.FIFO_DEPTH(DEPTH), .CS_GAP_CYCLES(GAP), .DELAY_TICKS(TICKS)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_tag(wr_tag), .wr_byte(wr_byte),
    .full(full), .empty(empty), .level(level), .busy(busy), .overflow(overflow),
    .spi_data(spi_data), .spi_cs_n(spi_cs_n), .spi_rdy(spi_rdy), .dc(dc)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s: got %0h want %0h", nm, act, want);
    end
  endtask

  // one clock: the SPI core model, the byte scoreboard and the CS-high monitor all run here
  task automatic tick();
    logic latch, pulse;
    @(negedge clk);
    latch = !spi_cs_n && (prev_cs || spi_rdy);
    if (latch) begin
      n_latch++;
      if (exp_q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL xfer_unexpected: got %0h want none", {dc, spi_data});
      end else chk("xfer", {23'd0, dc, spi_data}, {23'd0, exp_q.pop_front()});
    end
    if (!prev_cs && spi_cs_n) begin
      hi = 0;
      armed = !rst;
    end
    if (spi_cs_n) hi++;
    if (prev_cs && !spi_cs_n) begin
      last_hi = hi;
      n_fall++;
      if (armed) chk("cs_gap", 32'(hi >= GAP), 1);
    end
    if (rst) armed = 1'b0;
    chk("overflow", overflow, m_ovf);
    pulse = 1'b0;
    if (rst) tmr = 0;
    else if (latch) tmr = 16;
    else if (tmr > 0) begin
      tmr--;
      pulse = tmr == 0;
    end
    prev_cs = spi_cs_n;
    spi_rdy = pulse && core_en;
  endtask

  task automatic push(input logic [1:0] t, input logic [7:0] b, input bit ok);
    wr_en = 1'b1;
    wr_tag = t;
    wr_byte = b;
    if (ok && !t[1]) exp_q.push_back({t[0], b});
    if (!ok) m_ovf = 1'b1;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    m_ovf = 1'b0;
    exp_q.delete();
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_idle(input int max);
    for (int i = 0; i < max && busy !== 1'b0; i++) tick();
    chk("wait_idle", busy, 0);
  endtask

  task automatic wait_cs(input logic v, input int max);
    for (int i = 0; i < max && spi_cs_n !== v; i++) tick();
    chk("wait_cs", spi_cs_n, v);
  endtask

  initial begin
    repeat (3) tick();
    rst = 1'b0;
    chk("rst_cs_n", spi_cs_n, 1);
    chk("rst_data", spi_data, 0);
    chk("rst_dc", dc, 0);
    chk("rst_full", full, 0);
    chk("rst_empty", empty, 1);
    chk("rst_level", level, 0);
    chk("rst_busy", busy, 0);

    // burst CMD/DATA/DATA/END under one CS window
    f0 = n_fall; l0 = n_latch;
    push(CMD, 8'h2A, 1); push(DAT, 8'h00, 1); push(DAT, 8'h7F, 1); push(ENDT, 8'h00, 1);
    wait_idle(600);
    chk("t1_falls", n_fall - f0, 1);
    chk("t1_latches", n_latch - l0, 3);
    chk("t1_empty", empty, 1);
    chk("t1_cs_n", spi_cs_n, 1);
    chk("t1_dc_held", dc, 1);

    // CMD, DELAY 3 units of 4 ticks, CMD: CS high spans gap plus 12-tick delay
    f0 = n_fall; l0 = n_latch;
    push(CMD, 8'h01, 1); push(DLY, 8'd3, 1); push(CMD, 8'h11, 1);
    wait_idle(600);
    chk("t2_falls", n_fall - f0, 2);
    chk("t2_latches", n_latch - l0, 2);
    chk("t2_delay_hi", 32'(last_hi >= GAP + 12 && last_hi <= GAP + 15), 1);
    chk("t2_dc", dc, 0);

    // lone DATA with no END; CMD pushed during the gap starts right after it
    push(DAT, 8'hA5, 1);
    wait_cs(1'b0, 50);
    wait_cs(1'b1, 100);
    push(CMD, 8'h33, 1);
    wait_cs(1'b0, 50);
    chk("t6_gap_len", last_hi, GAP);
    wait_idle(200);

    // reset mid-transfer with 5 entries queued
    core_en = 1'b0;
    l0 = n_latch;
    push(DAT, 8'h5C, 1);
    for (int i = 0; i < 5; i++) push(DAT, 8'h61 + 8'(i), 1);
    tick(); tick();
    chk("t5_cs_low", spi_cs_n, 0);
    chk("t5_level5", level, 5);
    chk("t5_dc1", dc, 1);
    do_reset();
    chk("t5_cs_n", spi_cs_n, 1);
    chk("t5_level0", level, 0);
    chk("t5_dc0", dc, 0);
    chk("t5_data0", spi_data, 0);
    chk("t5_idle", busy, 0);
    spi_rdy = 1'b1;
    repeat (4) tick();
    chk("t5_no_load", spi_data, 0);
    chk("t5_cs_still", spi_cs_n, 1);
    chk("t5_latches", n_latch - l0, 1);

    // overfill while the core never answers
    do_reset();
    push(CMD, 8'h10, 1);
    for (int i = 0; i < 16; i++) push(DAT, 8'h20 + 8'(i), 1);
    chk("t3_level16", level, 16);
    chk("t3_full", full, 1);
    chk("t3_ovf0", overflow, 0);
    push(DAT, 8'hEE, 0);
    chk("t3_level_kept", level, 16);
    chk("t3_ovf1", overflow, 1);
    repeat (5) tick();
    chk("t3_ovf_sticky", overflow, 1);

    // push and pop on the same edge at full
    do_reset();
    push(CMD, 8'h10, 1);
    for (int i = 0; i < 16; i++) push(DAT, 8'h20 + 8'(i), 1);
    chk("t4_full", full, 1);
    wr_en = 1'b1; wr_tag = DAT; wr_byte = 8'h99;
    exp_q.push_back({1'b1, 8'h99});
    spi_rdy = 1'b1;
    core_en = 1'b1;
    tick();
    wr_en = 1'b0;
    chk("t4_level16", level, 16);
    chk("t4_full_still", full, 1);
    chk("t4_ovf0", overflow, 0);
    wait_idle(1000);
    chk("t4_drained", exp_q.size(), 0);
    chk("t4_empty", empty, 1);
    chk("t4_cs_n", spi_cs_n, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
